// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cpu_pkg                                                   |
// | Brief  : Shared types and constants for the 16-bit RISC pipeline.  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package cpu_pkg;

  localparam int              DATA_W    = 16;
  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [DATA_W-1:0] RESET_PC  = 16'h0000;

  // Fetch-stage control state; explicit one-bit encoding
  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  // What the IF/ID register does on the coming edge
  typedef enum logic [1:0] {
    IFA_HOLD   = 2'd0,
    IFA_LOAD   = 2'd1,
    IFA_BUBBLE = 2'd2
  } if_act_e;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

  // Byte address forced onto a word boundary
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : pc_next_sel                                               |
// | Brief  : Priority mux choosing the next PC and the IF/ID action.   |
// |          jump > branch > halt/out-of-range > stall > sequential.   |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module pc_next_sel #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] pc,
  input  logic              jump,
  input  logic [DATA_W-1:0] jump_target,
  input  logic              branch,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              in_range,
  input  logic              stall,
  input  logic              halted,
  output logic [DATA_W-1:0] pc_next,
  output logic [DATA_W-1:0] pc_plus4,
  output cpu_pkg::if_act_e  if_act
);
  import cpu_pkg::*;

  // Sequential successor, wrapping naturally at the top of the space
  always_comb begin
    pc_plus4 = pc + DATA_W'(4);
  end

  // First matching rule wins; a redirect squashes the wrong-path fetch
  always_comb begin
    pc_next = pc;
    if_act  = IFA_HOLD;
    if (jump) begin
      pc_next = word_align(jump_target);
      if_act  = IFA_BUBBLE;
    end else if (branch) begin
      pc_next = word_align(branch_target);
      if_act  = IFA_BUBBLE;
    end else if (halted || !in_range) begin
      // Stalls are ignored while halted; the PC simply parks
      if_act  = IFA_BUBBLE;
    end else if (stall) begin
      if_act  = IFA_HOLD;
    end else begin
      pc_next = pc_plus4;
      if_act  = IFA_LOAD;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : fetch_stage                                               |
// | Brief  : Instruction fetch: PC register, IF/ID register, stall,    |
// |          redirect, flush and sticky out-of-range halt.             |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module fetch_stage #(
  parameter int                DATA_W     = cpu_pkg::DATA_W,
  parameter int                IMEM_DEPTH = 15,
  parameter logic [DATA_W-1:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [DATA_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              jump,
  input  logic [DATA_W-1:0] jump_target,
  output logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              halted
);
  import cpu_pkg::*;

  // The word index is the whole PC above the byte offset, so raising the
  // depth far enough makes every address fetchable.
  localparam logic [31:0] c_imem_depth = 32'(IMEM_DEPTH);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  if_id_t            r_if_id;
  if_id_t            w_if_id_next;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] w_pc_next;
  logic [DATA_W-1:0] w_pc_plus4;
  logic              w_in_range;
  logic              w_redirect;
  logic              w_halted;
  if_act_e           w_if_act;

  // Address decode and redirect detection for the current PC
  always_comb begin
    w_in_range = (32'(r_pc[DATA_W-1:2]) < c_imem_depth);
    w_redirect = jump | branch_taken;
    w_halted   = (r_state == FS_HALT);
  end

  pc_next_sel #(
    .DATA_W (DATA_W)
  ) u_pc_next_sel (
    .pc            (r_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch        (branch_taken),
    .branch_target (branch_target),
    .in_range      (w_in_range),
    .stall         (stall),
    .halted        (w_halted),
    .pc_next       (w_pc_next),
    .pc_plus4      (w_pc_plus4),
    .if_act        (w_if_act)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= FS_RUN;
    else          r_state <= w_state_next;
  end

  // FSM next state: only a redirect leaves HALT
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FS_RUN:  if (!w_redirect && !w_in_range) w_state_next = FS_HALT;
      FS_HALT: if (w_redirect)                 w_state_next = FS_RUN;
      default: w_state_next = FS_RUN;
    endcase
  end

  // FSM output: halt flag comes straight from the state register
  always_comb begin
    halted = (r_state == FS_HALT);
  end

  // Program counter register
  always_ff @(posedge clk) begin
    if (!reset_n) r_pc <= RESET_PC;
    else          r_pc <= w_pc_next;
  end

  // IF/ID next value; flush squashes to a bubble but keeps pc_plus4
  always_comb begin
    w_if_id_next = r_if_id;
    case (w_if_act)
      IFA_LOAD: begin
        w_if_id_next.instr    = instruction;
        w_if_id_next.pc_plus4 = w_pc_plus4;
        w_if_id_next.valid    = 1'b1;
      end
      IFA_BUBBLE: begin
        w_if_id_next.instr = NOP_INSTR;
        w_if_id_next.valid = 1'b0;
      end
      default: ;
    endcase
    if (flush) begin
      w_if_id_next.instr = NOP_INSTR;
      w_if_id_next.valid = 1'b0;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_if_id.instr    <= NOP_INSTR;
      r_if_id.pc_plus4 <= '0;
      r_if_id.valid    <= 1'b0;
    end else begin
      r_if_id <= w_if_id_next;
    end
  end

  assign pc             = r_pc;
  assign if_id_instr    = r_if_id.instr;
  assign if_id_pc_plus4 = r_if_id.pc_plus4;
  assign if_id_valid    = r_if_id.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_fetch_stage                                            |
// | Brief  : Scoreboard bench for fetch_stage against a rule model.    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_fetch_stage;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] p4;
    logic        valid;
    logic        halted;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default depth 15)
  logic        reset_n, stall, flush, branch_taken, jump;
  logic [15:0] branch_target, jump_target, pc, instruction;
  logic [15:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, halted;

  // Instance whose memory spans the whole address space
  logic        wd_reset_n, wd_stall, wd_flush, wd_branch_taken, wd_jump;
  logic [15:0] wd_branch_target, wd_jump_target, wd_pc, wd_instruction;
  logic [15:0] wd_if_id_instr, wd_if_id_pc_plus4;
  logic        wd_if_id_valid, wd_halted;

  logic [15:0] imem [16];

  assign instruction    = (pc[15:6] == 10'd0) ? imem[pc[5:2]] : 16'hBAD0;
  assign wd_instruction = wd_pc ^ 16'h5A5A;

  fetch_stage u_dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .pc(pc),
    .instruction(instruction), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .halted(halted)
  );

  fetch_stage #(.IMEM_DEPTH(16384)) u_dut_wide (
    .clk(clk), .reset_n(wd_reset_n), .stall(wd_stall), .flush(wd_flush),
    .branch_taken(wd_branch_taken), .branch_target(wd_branch_target),
    .jump(wd_jump), .jump_target(wd_jump_target), .pc(wd_pc),
    .instruction(wd_instruction), .if_id_instr(wd_if_id_instr),
    .if_id_pc_plus4(wd_if_id_pc_plus4), .if_id_valid(wd_if_id_valid),
    .halted(wd_halted)
  );

  exp_t q_main[$];
  exp_t q_wide[$];
  int   nvec = 0;
  int   nerr = 0;

  // Reference model state: what the fetch stage should hold after each edge
  logic [15:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_halt;

  task automatic model_step(input logic rn, st, fl, jp, br,
                            input logic [15:0] jt, bt);
    if (!rn) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_p4 = 16'h0000;
      m_valid = 1'b0;  m_halt = 1'b0;
    end else begin
      if (m_halt) begin
        if (jp)      begin m_pc = jt & 16'hFFFC; m_halt = 1'b0; end
        else if (br) begin m_pc = bt & 16'hFFFC; m_halt = 1'b0; end
      end else if (jp || br) begin
        m_pc = jp ? (jt & 16'hFFFC) : (bt & 16'hFFFC);
        m_instr = 16'h0000; m_valid = 1'b0;
      end else if ((m_pc / 4) >= 15) begin
        m_halt = 1'b1; m_instr = 16'h0000; m_valid = 1'b0;
      end else if (!st) begin
        m_instr = imem[m_pc[5:2]];
        m_p4    = m_pc + 16'd4;
        m_pc    = m_pc + 16'd4;
        m_valid = 1'b1;
      end
      if (fl) begin m_instr = 16'h0000; m_valid = 1'b0; end
    end
  endtask

  task automatic drive(input logic rn, st, fl, jp, br,
                       input logic [15:0] jt, bt);
    exp_t e;
    @(negedge clk);
    reset_n = rn; stall = st; flush = fl; jump = jp; branch_taken = br;
    jump_target = jt; branch_target = bt;
    model_step(rn, st, fl, jp, br, jt, bt);
    e.pc = m_pc; e.instr = m_instr; e.p4 = m_p4; e.valid = m_valid; e.halted = m_halt;
    q_main.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic drive_wide(input logic rn, jp, input logic [15:0] jt,
                            input logic [15:0] e_pc, e_instr, e_p4,
                            input logic e_valid);
    exp_t e;
    @(negedge clk);
    wd_reset_n = rn; wd_jump = jp; wd_jump_target = jt;
    e.pc = e_pc; e.instr = e_instr; e.p4 = e_p4; e.valid = e_valid; e.halted = 1'b0;
    q_wide.push_back(e);
  endtask

  // Monitor: one expected record is consumed per edge after it was issued
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_main.size() > 0) begin
      e = q_main.pop_front();
      nvec++;
      if (pc !== e.pc || if_id_instr !== e.instr || if_id_valid !== e.valid ||
          halted !== e.halted || (e.valid && if_id_pc_plus4 !== e.p4)) begin
        nerr++;
        $display("FAIL main t=%0t got pc=%h instr=%h p4=%h v=%b h=%b, want pc=%h instr=%h p4=%h v=%b h=%b",
                 $time, pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted,
                 e.pc, e.instr, e.p4, e.valid, e.halted);
      end
    end
    if (q_wide.size() > 0) begin
      e = q_wide.pop_front();
      nvec++;
      if (wd_pc !== e.pc || wd_if_id_instr !== e.instr || wd_if_id_valid !== e.valid ||
          wd_halted !== e.halted || (e.valid && wd_if_id_pc_plus4 !== e.p4)) begin
        nerr++;
        $display("FAIL wide t=%0t got pc=%h instr=%h p4=%h v=%b h=%b, want pc=%h instr=%h p4=%h v=%b h=%b",
                 $time, wd_pc, wd_if_id_instr, wd_if_id_pc_plus4, wd_if_id_valid, wd_halted,
                 e.pc, e.instr, e.p4, e.valid, e.halted);
      end
    end
  end

  initial begin
    reset_n = 0; stall = 0; flush = 0; jump = 0; branch_taken = 0;
    jump_target = 0; branch_target = 0;
    wd_reset_n = 0; wd_stall = 0; wd_flush = 0; wd_jump = 0; wd_branch_taken = 0;
    wd_jump_target = 0; wd_branch_target = 0;
    for (int i = 0; i < 16; i++) imem[i] = 16'($urandom);
    imem[0] = 16'hA000; imem[1] = 16'hA001; imem[2] = 16'hA002; imem[3] = 16'hA003;

    // Reset, free-run, stall at pc=8, release
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    run(2);
    drive(1, 1, 0, 0, 0, 16'h0, 16'h0);
    drive(1, 1, 0, 0, 0, 16'h0, 16'h0);
    run(1);
    // Branch beats stall and is aligned; jump beats branch
    drive(1, 1, 0, 0, 1, 16'h0000, 16'h0006);
    run(1);
    drive(1, 0, 0, 1, 1, 16'h0000, 16'h0020);
    // Run into the halt region and sit there, then recover by jump
    run(21);
    drive(1, 0, 0, 1, 0, 16'h0008, 16'h0000);
    // Flush with stall, flush alone
    drive(1, 1, 1, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 1, 0, 0, 16'h0, 16'h0);
    // Reset in the middle of a stall
    drive(1, 1, 0, 0, 0, 16'h0, 16'h0);
    drive(0, 1, 0, 0, 0, 16'h0, 16'h0);
    run(2);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic rn, st, fl, jp, br;
      logic [15:0] jt, bt;
      rn = ($urandom_range(0, 59) != 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      jp = ($urandom_range(0, 19) == 0);
      br = ($urandom_range(0, 11) == 0);
      jt = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 79)) : 16'($urandom);
      bt = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 79)) : 16'($urandom);
      drive(rn, st, fl, jp, br, jt, bt);
    end

    // Wrap at the top of the address space on the full-depth instance
    drive_wide(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    drive_wide(1, 1, 16'hFFFE, 16'hFFFC, 16'h0000, 16'h0000, 1'b0);
    drive_wide(1, 0, 16'h0000, 16'h0000, 16'hA5A6, 16'h0000, 1'b1);
    drive_wide(1, 0, 16'h0000, 16'h0004, 16'h5A5A, 16'h0004, 1'b1);

    @(negedge clk);
    wd_jump = 0;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
